// File: rtl/approx_pkg.sv
// Shared types and default widths for the approximate-adder error monitors.
package approx_pkg;

  localparam int APPROX_WIDTH     = 16;
  localparam int APPROX_CNT_WIDTH = 16;
  localparam int APPROX_ACC_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mon_state_t;

endpackage

// File: rtl/error_distance_unit.sv
// Combinational exact sum and error distance between an exact and an approximate adder result.
module error_distance_unit #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] add1,
  input  logic [WIDTH-1:0] add2,
  input  logic [WIDTH:0]   approx,
  output logic [WIDTH:0]   exact,
  output logic [WIDTH:0]   ed
);

  assign exact = {1'b0, add1} + {1'b0, add2};
  // Subtract in whichever order keeps the result non-negative.
  assign ed    = (exact >= approx) ? (exact - approx) : (approx - exact);

endmodule

// File: rtl/approx_error_monitor16.sv
// Windowed error-statistics monitor for a 16-bit approximate adder: a stage-1 ED register
// feeding stage-2 count/sum/max accumulators, sequenced by an IDLE/RUN/DRAIN/DONE FSM.
module approx_error_monitor16
  import approx_pkg::*;
#(
  parameter int WIDTH     = APPROX_WIDTH,
  parameter int CNT_WIDTH = APPROX_CNT_WIDTH,
  parameter int ACC_WIDTH = APPROX_ACC_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] n_samples_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [WIDTH-1:0]     add1_i,
  input  logic [WIDTH-1:0]     add2_i,
  input  logic [WIDTH:0]       approx_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_WIDTH-1:0] sample_count_o,
  output logic [CNT_WIDTH-1:0] err_count_o,
  output logic [ACC_WIDTH-1:0] sum_ed_o,
  output logic [WIDTH:0]       max_ed_o
);

  mon_state_t           state_reg, state_next;
  logic [CNT_WIDTH-1:0] target_reg;
  logic [CNT_WIDTH-1:0] sample_count_reg;
  logic [CNT_WIDTH-1:0] err_count_reg;
  logic [ACC_WIDTH-1:0] sum_ed_reg, sum_ed_next;
  logic [ACC_WIDTH:0]   sum_ed_wide;
  logic [WIDTH:0]       max_ed_reg;
  logic                 s1_valid_reg;
  logic [WIDTH:0]       s1_ed_reg;

  logic [WIDTH:0]       exact_unused;
  logic [WIDTH:0]       ed;
  logic                 start_ok;
  logic                 accept;

  error_distance_unit #(.WIDTH(WIDTH)) u_edu (
    .add1   (add1_i),
    .add2   (add2_i),
    .approx (approx_i),
    .exact  (exact_unused),
    .ed     (ed)
  );

  assign ready_o  = (state_reg == RUN) && (sample_count_reg < target_reg);
  assign busy_o   = (state_reg == RUN) || (state_reg == DRAIN);
  assign done_o   = (state_reg == DONE);
  assign accept   = valid_i && ready_o;
  assign start_ok = start_i && ((state_reg == IDLE) || (state_reg == DONE));

  // Saturating accumulate: one extra bit catches the carry out.
  assign sum_ed_wide = {1'b0, sum_ed_reg} + (ACC_WIDTH+1)'(s1_ed_reg);
  assign sum_ed_next = sum_ed_wide[ACC_WIDTH] ? '1 : sum_ed_wide[ACC_WIDTH-1:0];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start_i) state_next = (n_samples_i == '0) ? DONE : RUN;
      end
      RUN: begin
        if (accept && (sample_count_reg == target_reg - 1'b1)) state_next = DRAIN;
      end
      DRAIN: begin
        if (!s1_valid_reg) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_reg        <= IDLE;
      target_reg       <= '0;
      sample_count_reg <= '0;
      err_count_reg    <= '0;
      sum_ed_reg       <= '0;
      max_ed_reg       <= '0;
      s1_valid_reg     <= 1'b0;
      s1_ed_reg        <= '0;
    end else begin
      state_reg    <= state_next;
      s1_valid_reg <= accept;
      if (accept) s1_ed_reg <= ed;
      // Stage 1 is always empty in IDLE/DONE, so a restart never drops a pending sample.
      if (start_ok) begin
        target_reg       <= n_samples_i;
        sample_count_reg <= '0;
        err_count_reg    <= '0;
        sum_ed_reg       <= '0;
        max_ed_reg       <= '0;
      end else begin
        if (accept) sample_count_reg <= sample_count_reg + 1'b1;
        if (s1_valid_reg) begin
          if (s1_ed_reg != '0) err_count_reg <= err_count_reg + 1'b1;
          sum_ed_reg <= sum_ed_next;
          if (s1_ed_reg > max_ed_reg) max_ed_reg <= s1_ed_reg;
        end
      end
    end
  end

  assign sample_count_o = sample_count_reg;
  assign err_count_o    = err_count_reg;
  assign sum_ed_o       = sum_ed_reg;
  assign max_ed_o       = max_ed_reg;

endmodule

// File: tb/tb_approx_error_monitor16.sv
// Randomised and directed bench for approx_error_monitor16 against a window-level behavioural model.
module tb_approx_error_monitor16;

  localparam int W = 16;
  localparam int C = 16;
  localparam int A = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [C-1:0] n_samples = '0;
  logic         valid = 1'b0;
  logic [W-1:0] add1 = '0;
  logic [W-1:0] add2 = '0;
  logic [W:0]   approx = '0;
  logic         ready, busy, done;
  logic [C-1:0] sample_count, err_count;
  logic [A-1:0] sum_ed;
  logic [W:0]   max_ed;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  approx_error_monitor16 dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .start_i        (start),
    .n_samples_i    (n_samples),
    .valid_i        (valid),
    .ready_o        (ready),
    .add1_i         (add1),
    .add2_i         (add2),
    .approx_i       (approx),
    .busy_o         (busy),
    .done_o         (done),
    .sample_count_o (sample_count),
    .err_count_o    (err_count),
    .sum_ed_o       (sum_ed),
    .max_ed_o       (max_ed)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint ref_ed(input longint x, input longint y, input longint ap);
    longint d;
    d = (x + y) - ap;
    return (d < 0) ? -d : d;
  endfunction

  // Window model: phase 0=idle 1=run 2=drain 3=done; pending ED lands in the stats one edge after accept.
  int     m_phase = 0;
  longint m_target = 0, m_count = 0, m_err = 0, m_sum = 0, m_max = 0;
  bit     m_pend = 1'b0;
  longint m_pend_ed = 0;

  always @(posedge clk) begin : model
    bit     m_ready, m_acc, had_pend;
    if (!rst_n) begin
      m_phase = 0; m_target = 0; m_count = 0;
      m_err = 0; m_sum = 0; m_max = 0; m_pend = 1'b0;
    end else begin
      had_pend = m_pend;
      if (m_pend) begin
        if (m_pend_ed != 0) m_err++;
        m_sum = m_sum + m_pend_ed;
        if (m_sum > 64'hFFFF_FFFF) m_sum = 64'hFFFF_FFFF;
        if (m_pend_ed > m_max) m_max = m_pend_ed;
      end
      m_ready = (m_phase == 1) && (m_count < m_target);
      m_acc   = m_ready && valid;
      m_pend  = m_acc;
      if (m_acc) m_pend_ed = ref_ed(longint'(add1), longint'(add2), longint'(approx));
      case (m_phase)
        0, 3: if (start) begin
          m_target = n_samples; m_count = 0; m_err = 0; m_sum = 0; m_max = 0;
          m_phase = (n_samples == 0) ? 3 : 1;
        end
        1: if (m_acc) begin
          m_count++;
          if (m_count == m_target) m_phase = 2;
        end
        2: if (!had_pend) m_phase = 3;
        default: m_phase = 0;
      endcase
    end
  end

  initial begin : compare
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("ready", 64'(ready), 64'((m_phase == 1) && (m_count < m_target)));
      chk("busy", 64'(busy), 64'((m_phase == 1) || (m_phase == 2)));
      chk("done", 64'(done), 64'(m_phase == 3));
      chk("sample_count", 64'(sample_count), 64'(m_count));
      chk("err_count", 64'(err_count), 64'(m_err));
      chk("sum_ed", 64'(sum_ed), 64'(m_sum));
      chk("max_ed", 64'(max_ed), 64'(m_max));
    end
  end

  task automatic drive(input bit st, input int nn, input bit v,
                       input logic [W-1:0] x, input logic [W-1:0] y, input logic [W:0] ap);
    start = st; n_samples = C'(nn); valid = v; add1 = x; add2 = y; approx = ap;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 0, 1'b0, '0, '0, '0);
  endtask

  task automatic wait_done(input int lim, output int cyc);
    cyc = 0;
    while (!done && cyc < lim) begin
      idle();
      cyc++;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL wait_done: done_o still 0 after %0d cycles, expected 1", lim);
    end
  endtask

  task automatic rand_sample(output logic [W-1:0] x, output logic [W-1:0] y, output logic [W:0] ap);
    logic [W:0] ex;
    x = W'($urandom);
    y = W'($urandom);
    ex = {1'b0, x} + {1'b0, y};
    case ($urandom_range(0, 2))
      0: ap = ex;
      1: ap = ex ^ (W+1)'($urandom_range(1, 255));
      default: ap = (W+1)'($urandom);
    endcase
  endtask

  initial begin : stim
    int c;
    logic [W-1:0] x, y;
    logic [W:0] ap;

    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_ready", 64'(ready), 0);
    chk("rst_done", 64'(done), 0);
    rst_n = 1'b1;
    idle();

    // exact single sample
    drive(1'b1, 1, 1'b0, '0, '0, '0);
    drive(1'b0, 0, 1'b1, 16'h1234, 16'h0F0F, 17'h02143);
    idle();
    chk("t1_done_k1", 64'(done), 0);
    idle();
    chk("t1_done_k2", 64'(done), 1);
    chk("t1_err", 64'(err_count), 0);
    chk("t1_sum", 64'(sum_ed), 0);
    chk("t1_max", 64'(max_ed), 0);
    chk("t1_count", 64'(sample_count), 1);
    $display("txn exact_single: count=%0d err=%0d sum=%0h", sample_count, err_count, sum_ed);

    // mixed window, back-to-back
    drive(1'b1, 3, 1'b0, '0, '0, '0);
    drive(1'b0, 0, 1'b1, 16'h000F, 16'h0001, 17'h10);
    drive(1'b0, 0, 1'b1, 16'h000F, 16'h0001, 17'h00);
    drive(1'b0, 0, 1'b1, 16'h000F, 16'h0001, 17'h20);
    wait_done(10, c);
    chk("t2_err", 64'(err_count), 2);
    chk("t2_sum", 64'(sum_ed), 64'h20);
    chk("t2_max", 64'(max_ed), 64'h10);
    $display("txn mixed3: err=%0d sum=%0h max=%0h", err_count, sum_ed, max_ed);

    // full-scale ED, valid held past the window
    drive(1'b1, 4, 1'b0, '0, '0, '0);
    repeat (4) drive(1'b0, 0, 1'b1, 16'hFFFF, 16'hFFFF, 17'h0);
    chk("t3_ready_gate", 64'(ready), 0);
    repeat (2) drive(1'b0, 0, 1'b1, 16'hFFFF, 16'hFFFF, 17'h0);
    wait_done(10, c);
    chk("t3_max", 64'(max_ed), 64'h1FFFE);
    chk("t3_sum", 64'(sum_ed), 64'h7FFF8);
    chk("t3_count", 64'(sample_count), 4);
    $display("txn fullscale: sum=%0h max=%0h", sum_ed, max_ed);

    // empty window then restart from DONE
    drive(1'b1, 0, 1'b0, '0, '0, '0);
    chk("t4_done", 64'(done), 1);
    chk("t4_sum", 64'(sum_ed), 0);
    chk("t4_max", 64'(max_ed), 0);
    drive(1'b1, 2, 1'b0, '0, '0, '0);
    chk("t4_restart_done", 64'(done), 0);
    chk("t4_restart_busy", 64'(busy), 1);
    repeat (2) begin rand_sample(x, y, ap); drive(1'b0, 0, 1'b1, x, y, ap); end
    wait_done(10, c);
    $display("txn empty_restart: count=%0d err=%0d", sample_count, err_count);

    // back-pressure gap with an ignored start
    drive(1'b1, 2, 1'b0, '0, '0, '0);
    drive(1'b0, 0, 1'b1, 16'h0001, 16'h0002, 17'h5);
    drive(1'b1, 7, 1'b0, '0, '0, '0);
    chk("t5_gap_sum", 64'(sum_ed), 2);
    idle();
    chk("t5_gap_hold", 64'(sum_ed), 2);
    drive(1'b0, 0, 1'b1, 16'h0001, 16'h0002, 17'h3);
    wait_done(10, c);
    chk("t5_count", 64'(sample_count), 2);
    chk("t5_sum", 64'(sum_ed), 2);
    $display("txn backpressure: count=%0d sum=%0h", sample_count, sum_ed);

    // reset mid-window
    drive(1'b1, 10, 1'b0, '0, '0, '0);
    repeat (5) drive(1'b0, 0, 1'b1, 16'h0100, 16'h0100, 17'h0);
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
    chk("t6_busy", 64'(busy), 0);
    chk("t6_done", 64'(done), 0);
    chk("t6_count", 64'(sample_count), 0);
    chk("t6_sum", 64'(sum_ed), 0);
    drive(1'b0, 0, 1'b1, 16'h0100, 16'h0100, 17'h0);
    chk("t6_no_accept", 64'(sample_count), 0);
    chk("t6_ready", 64'(ready), 0);
    $display("txn reset_mid: count=%0d busy=%0b", sample_count, busy);

    // random windows
    for (int w = 0; w < 15; w++) begin
      int nn;
      int k;
      nn = $urandom_range(1, 12);
      drive(1'b1, nn, 1'b0, '0, '0, '0);
      k = 0;
      while (!done && k < 200) begin
        rand_sample(x, y, ap);
        drive(($urandom_range(0, 7) == 0), $urandom_range(0, 20), ($urandom_range(0, 2) != 0), x, y, ap);
        k++;
      end
      wait_done(20, c);
      $display("txn random w=%0d n=%0d: count=%0d err=%0d sum=%0h max=%0h",
               w, nn, sample_count, err_count, sum_ed, max_ed);
    end

    // saturation of the ED sum
    drive(1'b1, 33000, 1'b0, '0, '0, '0);
    repeat (33000) drive(1'b0, 0, 1'b1, 16'hFFFF, 16'hFFFF, 17'h0);
    wait_done(10, c);
    chk("t8_sum_sat", 64'(sum_ed), 64'hFFFF_FFFF);
    chk("t8_err", 64'(err_count), 33000);
    chk("t8_max", 64'(max_ed), 64'h1FFFE);
    $display("txn saturate: count=%0d sum=%0h", sample_count, sum_ed);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/approx_error_monitor16.md
# approx_error_monitor16

Streaming error-statistics monitor that sits directly downstream of the 16-bit approximate adders. Per sample, it consumes the operand pair and the approximate adder's `WIDTH+1`-bit result, and computes the exact sum and the error distance (ED). Over a programmable window of N samples it accumulates error count, ED sum, and maximum ED, then reports completion. It is the characterisation harness for every approximate adder variant; the adder stays combinational and this block supplies all sequencing.

## Interface
- `WIDTH`, 16, operand width; the approximate result is `WIDTH+1` bits.
- `CNT_WIDTH`, 16, width of the sample-count and error-count registers.
- `ACC_WIDTH`, 32, width of the ED-sum accumulator.

- `clk_i`  in  1  single clock; all state changes on the rising edge.
- `rst_n_i`  in  1  reset; synchronous, active-low.
- `start_i`  in  1  pulse; opens a window. Honoured only in IDLE or DONE.
- `n_samples_i`  in  CNT_WIDTH  window length; sampled on an accepted `start_i`.
- `valid_i`  in  1  the sample inputs are valid.
- `ready_o`  out  1  the block accepts a sample this cycle.
- `add1_i`, `add2_i`  in  WIDTH  operands fed to the adder under test.
- `approx_i`  in  WIDTH+1  approximate result from the adder under test.
- `busy_o`  out  1  high in RUN and DRAIN.
- `done_o`  out  1  high in DONE; statistics are final.
- `sample_count_o`  out  CNT_WIDTH  samples accepted in the current window.
- `err_count_o`  out  CNT_WIDTH  samples with ED ≠ 0.
- `sum_ed_o`  out  ACC_WIDTH  saturating sum of ED.
- `max_ed_o`  out  WIDTH+1  largest ED in the window.

## Operation
- **FSM states:** IDLE, RUN, DRAIN, DONE.
- **IDLE → RUN:** on `start_i`. Load `target = n_samples_i` and clear all statistics and counters in the same edge.
- **Empty window:** if `start_i` arrives with `n_samples_i == 0`, go to DONE instead, with all statistics at 0.
- **RUN:**
  - `ready_o = (sample_count_o < target)`.
  - A sample is accepted on `valid_i & ready_o`, and `sample_count_o` increments.
  - When the accept that makes the count equal `target` occurs, go to DRAIN.
- **DRAIN:** `ready_o = 0`. Go to DONE once the stage-1 register is empty.
- **DONE:** `done_o = 1`, and statistics are held. `start_i` restarts exactly as from IDLE.
- `start_i` in RUN or DRAIN is ignored.
- **Stage 1 (accept edge):** register the following:
  - `exact = add1_i + add2_i`, zero-extended to `WIDTH+1`.
  - `ed = |exact − approx_i|`, `WIDTH+1` bits, unsigned.
  - A stage-1 valid flag.
- **Stage 2 (next edge, when the stage-1 valid flag is set):**
  - `err_count += (ed != 0)`.
  - `sum_ed += ed`, saturating at all-ones with no wrap.
  - `max_ed = max(max_ed, ed)`.
- The `err_count` and `sample_count` counters cannot overflow because they are bounded by `target`.
- **Reset** (any state, including mid-window):
  - State goes to IDLE.
  - `ready_o`, `busy_o`, `done_o` = 0.
  - All statistics = 0.
  - The stage-1 valid flag is cleared, so any in-flight sample is discarded.

## Timing
- A sample accepted at edge k appears in the statistics after edge k+1.
- `done_o` rises at edge k+2 after the last accept at edge k: RUN→DRAIN at k, stage-2 update at k+1, DRAIN→DONE at k+2.
- `ready_o` and `busy_o` are registered-state decodes with no combinational path from `valid_i`. `ready_o` may depend combinationally on `sample_count_o` and `target`.
- Throughput is one sample per cycle with back-to-back `valid_i`.
- When `valid_i` is low, stage 1 goes empty, and the statistics are unchanged on the following edge.
- Stage 2 uses the stage-1 contents from the previous edge, so it needs no forwarding.
- **Empty window:** `done_o` rises 1 cycle after `start_i`.

## Structure
- **Package `approx_pkg`:**
  - State enum `mon_state_t` (IDLE, RUN, DRAIN, DONE).
  - Default width constants `APPROX_WIDTH = 16`, `APPROX_CNT_WIDTH = 16`, `APPROX_ACC_WIDTH = 32`.
- **Sub-module `error_distance_unit`:** combinational. Inputs are the operands and the approximate result; outputs are `exact` and `ed`. It is reusable by the 8- and 32-bit monitor variants.
- **Top level:** holds the FSM, the stage-1 register, and the stage-2 accumulators.

## Test plan
- **Exact input, single sample:** `n_samples = 1`, `add1 = 0x1234`, `add2 = 0x0F0F`, `approx = 0x02143` (exact). Expect `done_o` 2 cycles after the accept, `err_count = 0`, `sum_ed = 0`, `max_ed = 0`, `sample_count = 1`.
- **Mixed window, 3 back-to-back samples:** all with `add1 = 0x000F`, `add2 = 0x0001` (exact 0x10), and `approx` = 0x10, 0x00, 0x20. Expect `err_count = 2`, `sum_ed = 0x20`, `max_ed = 0x10`.
- **Full-scale ED and ready gating:** `add1 = add2 = 0xFFFF` (exact 0x1FFFE), `approx = 0`, `n = 4`. Expect `max_ed = 0x1FFFE`, `sum_ed = 0x7FFF8`, and `ready_o` low after the 4th accept even with `valid_i` held high.
- **Empty window:** `start_i` with `n_samples = 0`. Expect `done_o` 1 cycle later with all statistics 0. Then `start_i` with `n = 2` clears state and restarts from DONE.
- **Back-pressure and ignored start:** toggle `valid_i` 1-0-1 with `n = 2`, and assert `start_i` during RUN. The second `start_i` is ignored, `sample_count` ends at 2, and gap cycles leave the statistics unchanged.
- **Reset mid-window:** drive `rst_n_i` low for 1 cycle after 5 of 10 accepts. Next cycle: IDLE with all outputs 0. A later sample with `valid_i` high is not accepted.
